// File: rtl/imem_pipe.sv
// imem_pipe: synchronous-read instruction memory with a valid/ready fetch
// port, a one-entry response register that holds under backpressure,
// misaligned-fetch detection and a 32-bit completed-fetch counter.
// Optional feature macro: IMEM_PROG_EN enables the byte-enabled programming
// write port; without it the prog_* ports exist but are ignored.
// Ports:
//   clk_i, rst_ni                  clock, async active-low reset
//   req_valid_i/req_ready_o        fetch request handshake
//   req_addr_i                     fetch byte address
//   rsp_valid_o/rsp_ready_i        response handshake
//   rsp_data_o, rsp_err_o          fetched word, misaligned flag
//   fetch_cnt_o                    completed responses (wraps)
//   prog_we_i/addr/be/wdata        programming write port
module imem_pipe #(
    parameter int IMEM_W = 14,
    parameter int W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [IMEM_W-1:0] req_addr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [W-1:0]      rsp_data_o,
    output logic              rsp_err_o,
    output logic [31:0]       fetch_cnt_o,
    input  logic              prog_we_i,
    input  logic [IMEM_W-1:0] prog_addr_i,
    input  logic [W/8-1:0]    prog_be_i,
    input  logic [W-1:0]      prog_wdata_i
);

    localparam int NB    = W / 8;
    localparam int OFS   = $clog2(NB);
    localparam int DEPTH = 2 ** (IMEM_W - OFS);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    logic [W-1:0] mem_q [DEPTH];

    state_e       state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         err_q, err_d;
    logic [31:0]  cnt_q, cnt_d;

    logic wr_en;
    logic accept;
    logic misal;
    logic unused_w;

`ifdef IMEM_PROG_EN
    assign wr_en = prog_we_i;
`else
    assign wr_en = 1'b0;
`endif

    assign unused_w = ^{prog_we_i, prog_addr_i[OFS-1:0]};

    assign rsp_valid_o = (state_q == FULL);
    assign rsp_data_o  = data_q;
    assign rsp_err_o   = err_q;
    assign fetch_cnt_o = cnt_q;

    // A programming write owns the memory for its cycle, so fetches stall.
    assign req_ready_o = !wr_en && (!rsp_valid_o || rsp_ready_i);
    assign accept      = req_valid_i && req_ready_o;
    assign misal       = (req_addr_i[OFS-1:0] != '0);

    // Contents are deliberately not reset so programs survive rst_ni.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++) begin
            if (wr_en && prog_be_i[b]) begin
                mem_q[prog_addr_i[IMEM_W-1:OFS]][b*8 +: 8] <=
                    prog_wdata_i[b*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        if (rsp_valid_o && rsp_ready_i) begin
            cnt_d = cnt_q + 32'd1;
        end
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (accept) begin
                    state_d = FULL;
                end else if (rsp_ready_i) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            err_d  = misal;
            data_d = misal ? '0 : mem_q[req_addr_i[IMEM_W-1:OFS]];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= EMPTY;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_imem_pipe.sv
// tb_imem_pipe: directed-vector bench for imem_pipe.
// Works in both builds; IMEM_PROG_EN selects the programming-port checks.
module tb_imem_pipe;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [13:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] fetch_cnt;
    logic        prog_we;
    logic [13:0] prog_addr;
    logic [3:0]  prog_be;
    logic [31:0] prog_wdata;

    int n_cmp = 0;
    int n_bad = 0;

    imem_pipe #(.IMEM_W(14), .W(32)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_addr_i   (req_addr),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .fetch_cnt_o  (fetch_cnt),
        .prog_we_i    (prog_we),
        .prog_addr_i  (prog_addr),
        .prog_be_i    (prog_be),
        .prog_wdata_i (prog_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = '0;
        rsp_ready  = 1'b0;
        prog_we    = 1'b0;
        prog_addr  = '0;
        prog_be    = '0;
        prog_wdata = '0;
        #1;
        check_eq("rst_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("rst_data", rsp_data, 32'd0);
        check_eq("rst_err", {31'd0, rsp_err}, 32'd0);
        check_eq("rst_cnt", fetch_cnt, 32'd0);
        check_eq("rst_ready", {31'd0, req_ready}, 32'd1);

        // Preload via backdoor: word0, word1, and 0x20.
        dut.mem_q[0] = 32'hA0A0_0001;
        dut.mem_q[1] = 32'hB1B1_0002;
        dut.mem_q[8] = 32'hAABB_CCDD;
`ifndef IMEM_PROG_EN
        dut.mem_q[4] = 32'h0000_0013;
`endif
        step();
        step();
        rst_n = 1'b1;
        step();

`ifdef IMEM_PROG_EN
        prog_we    = 1'b1;
        prog_addr  = 14'h0010;
        prog_be    = 4'hF;
        prog_wdata = 32'h0000_0013;
        #1;
        check_eq("prog_ready0", {31'd0, req_ready}, 32'd0);
        step();
        prog_we = 1'b0;
`endif

        // Basic fetch.
        req_valid = 1'b1;
        req_addr  = 14'h0010;
        rsp_ready = 1'b1;
        step();
        check_eq("f1_valid", {31'd0, rsp_valid}, 32'd1);
        check_eq("f1_data", rsp_data, 32'h0000_0013);
        check_eq("f1_err", {31'd0, rsp_err}, 32'd0);
        check_eq("f1_cnt0", fetch_cnt, 32'd0);
        req_valid = 1'b0;
        step();
        check_eq("f1_cnt1", fetch_cnt, 32'd1);
        check_eq("f1_empty", {31'd0, rsp_valid}, 32'd0);

        // Backpressure: word0 held while word1 waits.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 14'h0000;
        step();
        req_addr = 14'h0004;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_data", rsp_data, 32'hA0A0_0001);
            check_eq("bp_ready", {31'd0, req_ready}, 32'd0);
            check_eq("bp_cnt", fetch_cnt, 32'd1);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        check_eq("bp_rel_ready", {31'd0, req_ready}, 32'd1);
        step();
        check_eq("bp_w1", rsp_data, 32'hB1B1_0002);
        check_eq("bp_cnt2", fetch_cnt, 32'd2);
        req_valid = 1'b0;
        step();
        check_eq("bp_cnt3", fetch_cnt, 32'd3);
        check_eq("bp_empty", {31'd0, rsp_valid}, 32'd0);

        // Misaligned then aligned.
        req_valid = 1'b1;
        req_addr  = 14'h0006;
        step();
        check_eq("mis_err", {31'd0, rsp_err}, 32'd1);
        check_eq("mis_data", rsp_data, 32'd0);
        check_eq("mis_valid", {31'd0, rsp_valid}, 32'd1);
        req_addr = 14'h0010;
        step();
        check_eq("al_err", {31'd0, rsp_err}, 32'd0);
        check_eq("al_data", rsp_data, 32'h0000_0013);
        check_eq("al_cnt", fetch_cnt, 32'd4);
        req_valid = 1'b0;
        step();
        check_eq("hold_data", rsp_data, 32'h0000_0013);
        check_eq("hold_cnt", fetch_cnt, 32'd5);

        // Byte-enabled write to 0x20.
        prog_we    = 1'b1;
        prog_addr  = 14'h0020;
        prog_be    = 4'b0101;
        prog_wdata = 32'h1122_3344;
        req_valid  = 1'b1;
        req_addr   = 14'h0020;
        #1;
`ifdef IMEM_PROG_EN
        check_eq("be_ready0", {31'd0, req_ready}, 32'd0);
        step();
        check_eq("be_noacc", {31'd0, rsp_valid}, 32'd0);
        prog_we = 1'b0;
        #1;
        check_eq("be_ready1", {31'd0, req_ready}, 32'd1);
        step();
        check_eq("be_data", rsp_data, 32'hAA22_CC44);
`else
        check_eq("be_ignored_ready", {31'd0, req_ready}, 32'd1);
        step();
        prog_we = 1'b0;
        check_eq("be_data_ro", rsp_data, 32'hAABB_CCDD);
`endif
        req_valid = 1'b0;
        step();
        check_eq("be_cnt", fetch_cnt, 32'd6);

        // Reset while FULL and stalled.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 14'h0000;
        step();
        req_valid = 1'b0;
        check_eq("mr_full", {31'd0, rsp_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mr_valid", {31'd0, rsp_valid}, 32'd0);
        check_eq("mr_data", rsp_data, 32'd0);
        check_eq("mr_cnt", fetch_cnt, 32'd0);
        step();
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 1'b1;
        req_addr  = 14'h0010;
        step();
        check_eq("mr_keep", rsp_data, 32'h0000_0013);
        req_valid = 1'b0;
        step();
        check_eq("mr_cnt1", fetch_cnt, 32'd1);

        // Counter wrap.
        dut.cnt_q = 32'hFFFF_FFFF;
        req_valid = 1'b1;
        req_addr  = 14'h0004;
        step();
        check_eq("wr_data", rsp_data, 32'hB1B1_0002);
        req_valid = 1'b0;
        step();
        check_eq("wr_cnt", fetch_cnt, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_pipe.md
# imem_pipe

Parametrised, synchronous-read instruction memory with a valid/ready fetch port and a one-entry response register that holds under backpressure. Sits between the fetch stage and the instruction store and replaces the combinational lookup with a registered read of 1-cycle latency. Adds misaligned-fetch detection, a retired-fetch counter, and an optional byte-enabled programming write port.

## Interface
Parameters:
- IMEM_W, 14: byte-address width; addresses above this width are not decoded.
- W, 32: instruction/data width in bits; multiple of 8, at least 16.
- Derived: OFS = $clog2(W/8); DEPTH = 2**(IMEM_W-OFS) words.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_ni  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  fetch request valid.
- req_ready_o  out  1  fetch request accepted when high with req_valid_i.
- req_addr_i  in  IMEM_W  byte address of fetch.
- rsp_valid_o  out  1  response register holds a result.
- rsp_ready_i  in  1  consumer takes response.
- rsp_data_o  out  W  fetched word.
- rsp_err_o  out  1  response is a misaligned fetch.
- fetch_cnt_o  out  32  count of completed responses.
- prog_we_i  in  1  programming write strobe (IMEM_PROG_EN only).
- prog_addr_i  in  IMEM_W  programming byte address; low OFS bits ignored.
- prog_be_i  in  W/8  byte enables.
- prog_wdata_i  in  W  write data.

## Operation
- Storage: DEPTH words of W/8 bytes, byte-addressable for writes; word index = addr[IMEM_W-1:OFS]. Contents not reset; preserved across reset.
- Response register states: EMPTY (rsp_valid_o=0), FULL (rsp_valid_o=1).
- req_ready_o = !prog_we_i && (!rsp_valid_o || rsp_ready_i). Combinational path from rsp_ready_i and prog_we_i only.
- Accept (req_valid_i && req_ready_o) at edge: state -> FULL; if req_addr_i[OFS-1:0]==0, rsp_data_o <= mem[index], rsp_err_o <= 0; else rsp_data_o <= 0, rsp_err_o <= 1.
- FULL, rsp_ready_i=1, no accept: -> EMPTY; rsp_data_o/rsp_err_o keep last value.
- FULL, rsp_ready_i=0: rsp_data_o, rsp_err_o, rsp_valid_o held stable; no new request accepted.
- FULL, rsp_ready_i=1, accept same cycle: stays FULL, new result loaded (back-to-back, one fetch per cycle).
- Completion = rsp_valid_o && rsp_ready_i; fetch_cnt_o increments by 1 per completion (errors included), wraps 0xFFFF_FFFF -> 0.
- Programming write: at edge with prog_we_i=1, each byte b with prog_be_i[b]=1 written to mem[prog_addr_i index] byte b. Fetch blocked that cycle, so no read/write collision; a word written at edge N is returned by a fetch accepted at edge N+1 or later.

## Timing
- Reset (rst_ni=0, any time, asynchronous): rsp_valid_o=0, rsp_data_o=0, rsp_err_o=0, fetch_cnt_o=0, state EMPTY; any in-flight response discarded. req_ready_o=1 during reset whenever prog_we_i=0.
- Latency: request accepted at edge N -> rsp_valid_o=1 with data after edge N (visible in cycle N+1).
- Throughput: 1 fetch/cycle with rsp_ready_i held high and prog_we_i low.
- req_addr_i sampled only on accept edge; may change freely otherwise.
- Counter updates on the same edge as the completing handshake.

## Configuration
- IMEM_PROG_EN defined: programming port present and functional as described.
- IMEM_PROG_EN undefined: prog_* ports still exist but are ignored; memory read-only after simulation load (backdoor only); req_ready_o = !rsp_valid_o || rsp_ready_i.

## Test plan
- Reset then fetch: program word 0x0000_0013 at 0x0010 (IMEM_PROG_EN), fetch 0x0010 with rsp_ready_i=1 -> next cycle rsp_valid_o=1, rsp_data_o=0x0000_0013, rsp_err_o=0, fetch_cnt_o=1 after following edge.
- Backpressure: fetch 0x0000 then 0x0004 with rsp_ready_i=0 for 3 cycles -> rsp_data_o stable at word 0, req_ready_o=0; release -> word 1 on next cycle, no loss/duplication, fetch_cnt_o=2.
- Misaligned: fetch 0x0006 -> rsp_err_o=1, rsp_data_o=0; following aligned fetch clears rsp_err_o.
- Byte-enable write: word 0x20 = 0xAABB_CCDD, write 0x1122_3344 with prog_be_i=4'b0101 -> fetch returns 0xAA22_CC44; req_ready_o=0 during each write cycle.
- Reset mid-operation: assert rst_ni low while FULL and stalled -> rsp_valid_o, rsp_data_o, fetch_cnt_o go 0 immediately; after release, earlier programmed words read back unchanged.
- Counter wrap: force fetch_cnt_o to 0xFFFF_FFFF, complete one fetch -> 0x0000_0000.
